stamp_conv_sched: RTL and testbench
===================================

// Module: stamp_conv_sched
// PURPOSE
//  Time-shares one combinational BCD-date -> Unix-timestamp converter (time2stamp) between two requesters.
//  Port 0 is the live clock snapshot; port 1 is the alarm/set-time path.
//  Grants requests round-robin, registers the operand, waits a fixed settle window for the multicycle divider path, then returns the 64-bit stamp.
//  Sits between the clock/alarm logic and the single time2stamp instance.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles the operand is held before dp_stamp is sampled; legal range 1..15
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  req0_valid   in   1   requester 0 has a conversion pending
//  req0_time    in   56  {year_bcd[15:0],month,day,hour,minute,second} BCD, 8 b each after year
//  req0_ready   out  1   req0 accepted this cycle (transfer = valid & ready)
//  req1_valid   in   1   requester 1 has a conversion pending
//  req1_time    in   56  same packing as req0_time
//  req1_ready   out  1   req1 accepted this cycle
//  dp_time      out  56  registered operand driven to the converter, same packing
//  dp_stamp     in   64  converter result (combinational from dp_time)
//  rsp_valid    out  1   one-cycle pulse: rsp_stamp/rsp_id valid
//  rsp_id       out  1   requester that owns the response
//  rsp_stamp    out  64  captured timestamp, seconds since 1970-01-01 00:00:00
//  busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, dp_time=0, rsp_valid=0, rsp_id=0, rsp_stamp=0, cnt=0, last_grant=1, busy=0.
//  FSM states: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - readies are combinational: reqN_ready = IDLE & reqN_valid & grantN.
//   - grant: exactly one valid -> that port; both valid -> port != last_grant.
//   - on the accept edge: dp_time<=reqN_time, rsp_id<=N, last_grant<=N, cnt<=SETTLE_CYCLES-1, state<=WAIT.
//  WAIT
//   - cnt decrements each edge.
//   - on the edge where cnt==0: rsp_stamp<=dp_stamp, rsp_valid<=1, state<=RESP.
//  RESP
//   - rsp_valid high for exactly this cycle; both readies are 0.
//   - next edge: rsp_valid<=0, state<=IDLE.
//  Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge.
//  Throughput: one conversion per SETTLE_CYCLES+2 cycles at most.
//  dp_time is held constant from the accept edge until the next accept; the converter input never glitches mid-window.
//  There is no response back-pressure; the consumer must sample on rsp_valid.
//  Requester rules: hold reqN_time stable while valid; valid must not depend on ready.
//  A request arriving during WAIT/RESP waits in IDLE; the held request is not dropped.
//  Simultaneous first requests after reset: port 0 wins (last_grant=1).
//  rst asserted mid-WAIT/RESP: in-flight conversion discarded, no rsp_valid, all outputs to reset values immediately.
//  rsp_stamp is full 64 b straight from dp_stamp; no truncation or sign handling.
// CONFIGURATION
//  Macro STAMP_BCD_CHECK_EN.
//  Defined:
//   - adds port rsp_err (out, 1).
//   - at accept, operand is checked: every nibble <=9, month 01..12, day 01..31, hour<=23, minute<=59, second<=59.
//   - result is registered with dp_time.
//   - on error: rsp_err=1 and rsp_stamp forced to 0 at capture; rsp_valid timing unchanged.
//   - rsp_err resets to 0 and follows rsp_stamp update rules.
//  Undefined: no rsp_err port, no check logic, operand passed unchecked.
// TESTING
//  1. req0 2000-01-01 00:00:00 (56'h2000_01_01_00_00_00), SETTLE_CYCLES=4
//     -> rsp_valid 4 edges after accept, rsp_id=0, rsp_stamp=946684800.
//  2. req1 2024-03-01 00:00:00 -> rsp_id=1, rsp_stamp=1709251200 (leap-year post-Feb path).
//  3. req0 and req1 valid in the same cycle after reset, both held
//     -> req0 served first, req1 accepted the first IDLE cycle after RESP; two rsp pulses, ids 0 then 1.
//  4. req0 held continuously with req1 pulsing -> grants alternate 0,1,0,1; no starvation.
//  5. rst asserted 2 cycles into WAIT -> no rsp_valid; busy=0 and rsp_stamp=0 immediately.
//     After release, 1970-01-01 00:00:00 -> rsp_stamp=0, rsp_valid pulses.
//  6. STAMP_BCD_CHECK_EN: month=8'h13 -> rsp_err=1, rsp_stamp=0.
//     second=8'h5A -> rsp_err=1.
//     Valid date -> rsp_err=0.

Source files
------------

// File: rtl/stamp_conv_sched.sv
// Round-robin scheduler that time-shares one combinational BCD-date -> Unix-stamp converter between two requesters.
// Optional operand validation and the rsp_err port are enabled by defining STAMP_BCD_CHECK_EN.
module stamp_conv_sched #(
  parameter  int unsigned SETTLE_CYCLES = 4,
  localparam int unsigned TIME_W        = 56,
  localparam int unsigned STAMP_W       = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [TIME_W-1:0]  req0_time,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [TIME_W-1:0]  req1_time,
  output logic               req1_ready,
  output logic [TIME_W-1:0]  dp_time,
  input  logic [STAMP_W-1:0] dp_stamp,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [STAMP_W-1:0] rsp_stamp,
  output logic               busy
`ifdef STAMP_BCD_CHECK_EN
  ,
  output logic               rsp_err
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic               grant0, grant1;

  // Next-state and handshake decode; on a tie the port not served last wins.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    grant0     = req0_valid & ~grant1;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) state_nxt = WAIT;
      end
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

`ifdef STAMP_BCD_CHECK_EN
  logic op_err;

  function automatic logic bcd_ok(input logic [TIME_W-1:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(TIME_W / 4); i++)
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    if (t[39:32] < 8'h01 || t[39:32] > 8'h12) ok = 1'b0;
    if (t[31:24] < 8'h01 || t[31:24] > 8'h31) ok = 1'b0;
    if (t[23:16] > 8'h23) ok = 1'b0;
    if (t[15:8]  > 8'h59) ok = 1'b0;
    if (t[7:0]   > 8'h59) ok = 1'b0;
    return ok;
  endfunction
`endif

  // Operand capture, settle countdown and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_time    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_stamp  <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
`ifdef STAMP_BCD_CHECK_EN
      op_err     <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      busy      <= (state_nxt != IDLE);
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            dp_time    <= req1_ready ? req1_time : req0_time;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
            cnt        <= CNT_W'(SETTLE_CYCLES - 1);
`ifdef STAMP_BCD_CHECK_EN
            op_err     <= ~bcd_ok(req1_ready ? req1_time : req0_time);
`endif
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
`ifdef STAMP_BCD_CHECK_EN
            rsp_stamp <= op_err ? '0 : dp_stamp;
            rsp_err   <= op_err;
`else
            rsp_stamp <= dp_stamp;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stamp_conv_sched.sv
// Directed bench for stamp_conv_sched with a reference BCD->Unix converter and an accept-time scoreboard.
// Build with STAMP_BCD_CHECK_EN defined to also exercise rsp_err.
module tb_stamp_conv_sched;

  localparam int unsigned SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [55:0] req0_time, req1_time;
  logic        req0_ready, req1_ready;
  logic [55:0] dp_time;
  logic [63:0] dp_stamp;
  logic        rsp_valid, rsp_id, busy;
  logic [63:0] rsp_stamp;
`ifdef STAMP_BCD_CHECK_EN
  logic        rsp_err;
`endif

  stamp_conv_sched #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_time  (req0_time),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_time  (req1_time),
    .req1_ready (req1_ready),
    .dp_time    (dp_time),
    .dp_stamp   (dp_stamp),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_stamp  (rsp_stamp),
    .busy       (busy)
`ifdef STAMP_BCD_CHECK_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference converter standing in for the shared time2stamp block.
  function automatic longint b2(input logic [7:0] b);
    return longint'(b[7:4]) * 10 + longint'(b[3:0]);
  endfunction

  function automatic bit is_leap(input longint y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic longint mdays(input longint m, input longint y);
    case (m)
      2:             return is_leap(y) ? 29 : 28;
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  function automatic logic [63:0] t2s(input logic [55:0] t);
    longint y, mo, d, days;
    y    = b2(t[55:48]) * 100 + b2(t[47:40]);
    mo   = b2(t[39:32]);
    d    = b2(t[31:24]);
    days = 0;
    for (longint yy = 1970; yy < y; yy++) days += is_leap(yy) ? 366 : 365;
    for (longint m = 1; m < mo && m <= 12; m++) days += mdays(m, y);
    days += d - 1;
    return 64'(days * 86400 + b2(t[23:16]) * 3600 + b2(t[15:8]) * 60 + b2(t[7:0]));
  endfunction

  always_comb dp_stamp = t2s(dp_time);

  typedef struct {
    logic        id;
    logic [55:0] tm;
    logic [63:0] stamp;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          id_log[$];
  int          n_chk = 0, n_pass = 0, n_fail = 0;
  int          cyc = 0, n_acc = 0, n_rsp = 0;
  int          acc_cyc[2];
  bit          acc0_edge, acc1_edge;
  bit          exp_err = 1'b0;
  logic [63:0] last_stamp;
  logic        last_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic id, input logic [55:0] t);
    exp_t e;
    e.id    = id;
    e.tm    = t;
    e.err   = exp_err;
    e.stamp = exp_err ? 64'd0 : t2s(t);
    e.cyc   = cyc;
    sb.push_back(e);
    acc_cyc[int'(id)] = cyc;
    n_acc++;
  endfunction

  // Record each handshake as it happens and queue the expected response.
  always @(posedge clk) begin
    cyc++;
    acc0_edge = 1'b0;
    acc1_edge = 1'b0;
    if (!rst) begin
      if (req0_valid && req0_ready) begin acc0_edge = 1'b1; push_exp(1'b0, req0_time); end
      if (req1_valid && req1_ready) begin acc1_edge = 1'b1; push_exp(1'b1, req1_time); end
    end
  end

  // Response checker: pop and compare whenever a response pulse is seen.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      n_rsp++;
      id_log.push_back(int'(rsp_id));
      last_stamp = rsp_stamp;
      last_id    = rsp_id;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_stamp", rsp_stamp, e.stamp);
        chk("latency", 64'(cyc - e.cyc), 64'(SETTLE));
        chk("dp_time_held", 64'(dp_time), 64'(e.tm));
        chk("busy_in_resp", 64'(busy), 64'd1);
        chk("ready_in_resp", 64'({req0_ready, req1_ready}), 64'd0);
`ifdef STAMP_BCD_CHECK_EN
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
`endif
      end
    end
  end

  task automatic wait_acc(input int p, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      got = (p == 0) ? acc0_edge : acc1_edge;
    end
    chk($sformatf("accept%0d", p), 64'(got), 64'd1);
  endtask

  task automatic send(input int p, input logic [55:0] t);
    if (p == 0) begin req0_time = t; req0_valid = 1'b1; end
    else        begin req1_time = t; req1_valid = 1'b1; end
    wait_acc(p, 40);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, prior;
    int exp_ids[4];
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_time  = '0;
    req1_time  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_stamp", rsp_stamp, 64'd0);
    chk("rst_dp_time", 64'(dp_time), 64'd0);
`ifdef STAMP_BCD_CHECK_EN
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
`endif
    rst = 1'b0;

    // 2000-01-01 on port 0
    send(0, 56'h2000_01_01_00_00_00);
    drain(40);
    chk("t1_stamp", last_stamp, 64'd946684800);
    chk("t1_id", 64'(last_id), 64'd0);

    // 2024-03-01 on port 1, past a leap February
    send(1, 56'h2024_03_01_00_00_00);
    drain(40);
    chk("t2_stamp", last_stamp, 64'd1709251200);
    chk("t2_id", 64'(last_id), 64'd1);

    // Simultaneous first requests after reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    id_log.delete();
    req0_time  = 56'h1999_12_31_23_59_59;
    req1_time  = 56'h2038_01_19_03_14_08;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("t3_ready0", 64'(req0_ready), 64'd1);
    chk("t3_ready1", 64'(req1_ready), 64'd0);
    wait_acc(0, 10);
    req0_valid = 1'b0;
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_ready1_wait", 64'(req1_ready), 64'd0);
    wait_acc(1, 40);
    req1_valid = 1'b0;
    chk("t3_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(SETTLE + 2));
    drain(40);
    chk("t3_nrsp", 64'(id_log.size()), 64'd2);
    chk("t3_id0", 64'(id_log[0]), 64'd0);
    chk("t3_id1", 64'(id_log[1]), 64'd1);

    // Port 0 held, port 1 re-requesting after each accept
    id_log.delete();
    base       = n_acc;
    req0_time  = 56'h2012_02_29_12_00_00;
    req1_time  = 56'h2100_03_01_00_00_01;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (n_acc >= base + 4) break;
      req1_valid = !acc1_edge;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain(40);
    exp_ids = '{0, 1, 0, 1};
    chk("t4_nrsp", 64'(id_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_id%0d", i), 64'(id_log[i]), 64'(exp_ids[i]));

    // Reset two cycles into WAIT discards the conversion
    send(1, 56'h2001_09_09_01_46_40);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rsp_stamp", rsp_stamp, 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rsp_id", 64'(rsp_id), 64'd0);
    chk("t5_dp_time", 64'(dp_time), 64'd0);
    sb.delete();
    prior = n_rsp;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_rsp", 64'(n_rsp), 64'(prior));
    send(0, 56'h1970_01_01_00_00_00);
    drain(40);
    chk("t5_one_rsp", 64'(n_rsp), 64'(prior + 1));
    chk("t5_epoch", last_stamp, 64'd0);

`ifdef STAMP_BCD_CHECK_EN
    exp_err = 1'b1;
    send(0, 56'h2023_13_01_00_00_00);
    drain(40);
    chk("t6_month_err", 64'(rsp_err), 64'd1);
    chk("t6_month_stamp", rsp_stamp, 64'd0);
    send(1, 56'h2023_06_15_12_30_5A);
    drain(40);
    chk("t6_sec_err", 64'(rsp_err), 64'd1);
    exp_err = 1'b0;
    send(0, 56'h2000_01_01_00_00_00);
    drain(40);
    chk("t6_ok_err", 64'(rsp_err), 64'd0);
    chk("t6_ok_stamp", rsp_stamp, 64'd946684800);
`endif

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
